// File: rtl/nic_pkg.sv
// Shared NIC definitions: register map, default packet width and the
// port-arbiter state encoding.
package nic_pkg;

  localparam int unsigned NIC_PACKET_WIDTH = 64;

  localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_CHK,
    ST_WR,
    ST_RD,
    ST_CAP,
    ST_DONE
  } arb_state_e;

endpackage

// File: rtl/nic_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found searching upward (with wrap) from ptr.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_gdbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_pick;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    w_dbl  = {req, req} >> ptr;
    w_rot  = w_dbl[N-1:0];
    w_pick = w_rot & (-w_rot);
    w_gdbl = {w_pick, w_pick} << ptr;
    grant  = w_gdbl[2*N-1:N];
  end

endmodule

// File: rtl/nic_port_arbiter.sv
// Shares one NIC register port among NUM_REQ requesters: round-robin grant,
// status polling with timeout, then a buffer write (send) or read (receive).
module nic_port_arbiter
  import nic_pkg::*;
#(
  parameter int unsigned PACKET_WIDTH = NIC_PACKET_WIDTH,
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned MAX_POLL     = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_wr,
  input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]              done,
  output logic                            err,
  output logic [PACKET_WIDTH-1:0]         rdata,
  output logic [1:0]                      addr,
  output logic [PACKET_WIDTH-1:0]         d_in,
  output logic                            nicEn,
  output logic                            nicEnWR,
  input  logic [PACKET_WIDTH-1:0]         d_out
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(MAX_POLL + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_POLL - 1);

  arb_state_e              r_state;
  arb_state_e              w_next;
  logic [PW-1:0]           r_ptr;
  logic [NUM_REQ-1:0]      r_gnt;
  logic [PW-1:0]           r_gidx;
  logic                    r_wr;
  logic [PACKET_WIDTH-1:0] r_wdata;
  logic [CW-1:0]           r_cnt;
  logic                    r_err;
  logic [PACKET_WIDTH-1:0] r_rdata;

  logic [NUM_REQ-1:0]      w_grant;
  logic [PW-1:0]           w_gidx;
  logic                    w_wr_sel;
  logic [PACKET_WIDTH-1:0] w_wdata_sel;
  logic                    w_cnt_inc;
  logic                    w_timeout;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req  (req),
    .ptr  (r_ptr),
    .grant(w_grant)
  );

  always_comb begin
    w_gidx      = '0;
    w_wdata_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gidx      = PW'(i);
        w_wdata_sel = req_wdata[i*PACKET_WIDTH +: PACKET_WIDTH];
      end
    end
    w_wr_sel = |(req_wr & w_grant);
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_inc = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: if (|req) w_next = ST_POLL;
      ST_POLL: w_next = ST_CHK;
      ST_CHK: begin
        if (r_wr && !d_out[0]) begin
          w_next = ST_WR;
        end else if (!r_wr && d_out[0]) begin
          w_next = ST_RD;
        end else if (r_cnt == CNT_LAST) begin
          w_next    = ST_DONE;
          w_timeout = 1'b1;
        end else begin
          w_next    = ST_POLL;
          w_cnt_inc = 1'b1;
        end
      end
      ST_WR:   w_next = ST_DONE;
      ST_RD:   w_next = ST_CAP;
      ST_CAP:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_gidx  <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_gnt   <= w_grant;
            r_gidx  <= w_gidx;
            r_wr    <= w_wr_sel;
            r_wdata <= w_wdata_sel;
            r_cnt   <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_CHK: begin
          if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
          r_err <= w_timeout;
        end
        ST_CAP:  r_rdata <= d_out;
        ST_DONE: r_ptr <= (r_gidx == PW'(NUM_REQ - 1)) ? '0 : r_gidx + PW'(1);
        default: ;
      endcase
    end
  end

  // NIC strobes come only from registered state, never from req or d_out.
  always_comb begin
    nicEn   = 1'b0;
    nicEnWR = 1'b0;
    addr    = NIC_ADDR_IN_BUF;
    d_in    = '0;
    case (r_state)
      ST_POLL: begin
        nicEn = 1'b1;
        addr  = r_wr ? NIC_ADDR_OUT_STAT : NIC_ADDR_IN_STAT;
      end
      ST_WR: begin
        nicEn   = 1'b1;
        nicEnWR = 1'b1;
        addr    = NIC_ADDR_OUT_BUF;
        d_in    = r_wdata;
      end
      ST_RD: begin
        nicEn = 1'b1;
        addr  = NIC_ADDR_IN_BUF;
      end
      default: ;
    endcase
  end

  assign done  = (r_state == ST_DONE) ? r_gnt : '0;
  assign err   = (r_state == ST_DONE) & r_err;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_nic_port_arbiter.sv
// Bench for nic_port_arbiter: behavioural NIC plus a transaction-level
// reference model (round-robin order, latency formula, rdata history).
module tb_nic_port_arbiter;
  import nic_pkg::*;

  localparam int unsigned M = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   req = '0;
  logic [1:0]   req_wr = '0;
  logic [127:0] req_wdata = '0;
  logic [1:0]   done;
  logic         err;
  logic [63:0]  rdata;
  logic [1:0]   addr;
  logic [63:0]  d_in;
  logic         nicEn;
  logic         nicEnWR;
  logic [63:0]  d_out = '0;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nic_port_arbiter #(
    .PACKET_WIDTH(64),
    .NUM_REQ(2),
    .MAX_POLL(M)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_wr   (req_wr),
    .req_wdata(req_wdata),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .addr     (addr),
    .d_in     (d_in),
    .nicEn    (nicEn),
    .nicEnWR  (nicEnWR),
    .d_out    (d_out)
  );

  // NIC model: the first nic_fail status polls of a transaction report "not ready".
  int          nic_fail = 0;
  logic [63:0] nic_in_buf = '0;
  int          nic_polls = 0;
  logic [63:0] nic_out_buf = '0;

  always @(posedge clk) begin
    if (!reset_n || done != 2'b00) nic_polls <= 0;
    else if (nicEn && !nicEnWR && addr[0]) nic_polls <= nic_polls + 1;
    if (nicEn && !nicEnWR) begin
      if (addr[0])
        d_out <= {$urandom, 31'($urandom),
                  (addr == 2'b11) ? (nic_polls < nic_fail) : (nic_polls >= nic_fail)};
      else
        d_out <= nic_in_buf;
    end
    if (nicEn && nicEnWR) nic_out_buf <= d_in;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          m_ptr = 0;
  logic [63:0] m_rdata = '0;

  // Called at the negedge of an IDLE cycle (cycle 0); returns at the negedge of the following IDLE cycle.
  task automatic run_txn(input string tag, input logic [1:0] rq, input logic [1:0] wr,
                         input logic [63:0] wd0, input logic [63:0] wd1, input int fail,
                         input logic [63:0] inbuf, input bit drop);
    int g, exp_cyc, n, done_cyc, poll_cnt, first_poll, wr_cyc, rd_cyc;
    bit is_wr, ok, err_bad, err_seen;
    logic [63:0] wd_g, dwr;
    logic [1:0] done_seen, wr_addr;
    g = -1;
    for (int i = 0; i < 2; i++)
      if (g < 0 && rq[(m_ptr + i) % 2]) g = (m_ptr + i) % 2;
    is_wr   = wr[g];
    wd_g    = (g == 1) ? wd1 : wd0;
    ok      = (fail < int'(M));
    exp_cyc = ok ? ((is_wr ? 4 : 5) + 2 * fail) : (2 * int'(M) + 1);

    req = rq; req_wr = wr; req_wdata = {wd1, wd0};
    nic_fail = fail; nic_in_buf = inbuf;
    n = 0; done_cyc = -1; poll_cnt = 0; first_poll = -1; wr_cyc = -1; rd_cyc = -1;
    err_bad = 0; err_seen = 0; done_seen = '0; dwr = '0; wr_addr = '0;
    while (done_cyc < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        req_wr = ~wr;
        if (drop) req = '0;
      end
      if (nicEn && !nicEnWR && addr == (is_wr ? 2'b11 : 2'b01)) begin
        poll_cnt++;
        if (first_poll < 0) first_poll = n;
      end
      if (nicEn && nicEnWR) begin wr_cyc = n; dwr = d_in; wr_addr = addr; end
      if (nicEn && !nicEnWR && addr == 2'b00) rd_cyc = n;
      if (err && done == 2'b00) err_bad = 1;
      if (done != 2'b00) begin done_cyc = n; done_seen = done; err_seen = err; end
    end
    if (!is_wr && ok) m_rdata = inbuf;
    m_ptr = (g + 1) % 2;

    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
    check({tag, "_done_onehot"}, 64'(done_seen), 64'(2'b01 << g));
    check({tag, "_err"}, 64'(err_seen), 64'(!ok));
    check({tag, "_rdata"}, rdata, m_rdata);
    check({tag, "_polls"}, 64'(poll_cnt), 64'(ok ? fail + 1 : int'(M)));
    check({tag, "_first_poll"}, 64'(first_poll), 64'(1));
    check({tag, "_err_without_done"}, 64'(err_bad), 64'(0));
    check({tag, "_wr_cycle"}, 64'(wr_cyc), 64'((is_wr && ok) ? exp_cyc - 1 : -1));
    check({tag, "_rd_cycle"}, 64'(rd_cyc), 64'((!is_wr && ok) ? exp_cyc - 2 : -1));
    if (is_wr && ok) begin
      check({tag, "_d_in"}, dwr, wd_g);
      check({tag, "_wr_addr"}, 64'(wr_addr), 64'(2'b10));
    end
    @(negedge clk);
    check({tag, "_idle_after_done"}, 64'({done, nicEn}), 64'(0));
    if (is_wr && ok) check({tag, "_nic_out_buf"}, nic_out_buf, wd_g);
  endtask

  initial begin
    // Reset held with both requests pending
    reset_n = 1'b0; req = 2'b11; req_wr = 2'b11;
    repeat (3) begin
      @(negedge clk);
      check("reset_ctrl", 64'({done, err, addr, nicEn, nicEnWR}), 64'(0));
      check("reset_data", rdata | d_in, 64'(0));
    end
    req = '0;
    reset_n = 1'b1;
    @(negedge clk);

    run_txn("send0", 2'b01, 2'b01, 64'hA5A5_0000_0000_0001, 64'h0, 0, 64'h0, 0);
    run_txn("recv1", 2'b10, 2'b00, 64'h0, 64'h0, 0, 64'h1234, 0);
    run_txn("cont_a", 2'b11, 2'b11, 64'h1111, 64'h2222, 0, 64'h0, 0);
    run_txn("cont_b", 2'b11, 2'b11, 64'h3333, 64'h4444, 0, 64'h0, 0);
    run_txn("cont_c", 2'b11, 2'b11, 64'h5555, 64'h6666, 0, 64'h0, 0);
    run_txn("send_retry", 2'b10, 2'b10, 64'h0, 64'hBEEF_0001, 2, 64'h0, 0);
    run_txn("recv_timeout", 2'b01, 2'b00, 64'h0, 64'h0, 100, 64'hDEAD, 0);
    run_txn("send_timeout", 2'b10, 2'b10, 64'h0, 64'hCAFE, M, 64'h0, 0);
    run_txn("recv_last_poll", 2'b01, 2'b00, 64'h0, 64'h0, M - 1, 64'h77, 0);
    run_txn("drop_req", 2'b10, 2'b00, 64'h0, 64'h0, 1, 64'h99, 1);

    // Reset during CHK of a send
    req = 2'b01; req_wr = 2'b01; req_wdata = {64'h0, 64'hF00D}; nic_fail = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_ctrl", 64'({done, err, addr, nicEn, nicEnWR}), 64'(0));
    check("midreset_data", rdata | d_in, 64'(0));
    m_ptr = 0; m_rdata = '0;
    repeat (2) begin
      @(negedge clk);
      check("midreset_no_done", 64'({done, nicEn}), 64'(0));
    end
    req = '0;
    reset_n = 1'b1;
    @(negedge clk);
    run_txn("after_reset", 2'b11, 2'b01, 64'h0123_4567, 64'h89AB, 0, 64'h0, 0);

    for (int k = 0; k < 40; k++) begin
      run_txn("rand", 2'($urandom_range(1, 3)), 2'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(0, 5)), {$urandom, $urandom},
              $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
